// File: rtl/bat_amateur_pkg.sv
// Shared definitions for the bat_amateur core and its program loader:
// loader state encoding, RAM read/write strobe levels and the default bus width.
package bat_amateur_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 16;

  localparam logic RAM_RW_WRITE = 1'b1;
  localparam logic RAM_RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RELEASE = 3'd5
  } load_state_e;

endpackage

// File: rtl/bat_amateur_loader.sv
// Program loader: halts and resets the bat_amateur core, streams 16-bit words
// into consecutive RAM addresses, then hands the bus and the core back.
//
//   state   | meaning
//   IDLE    | core running, loader off the bus, waiting for LOAD_START
//   SETTLE  | core reset + halted, bus not yet driven, SETTLE_CYCLES long
//   FETCH   | waiting for the next program word on IN_DATA/IN_VALID
//   WRITE   | one-cycle RAM write strobe at START_ADDR + count
//   HOLD    | bus held with strobe low (RAM hold time), count advances
//   RELEASE | bus and HALT released, core still in reset, DONE pulse
module bat_amateur_loader
  import bat_amateur_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] START_ADDR    = '0,
  parameter int                       SETTLE_CYCLES = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     LOAD_START,
  input  logic [ADDRESS_WIDTH-1:0] LOAD_LEN,
  input  logic [15:0]              IN_DATA,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic                     CPU_RST,
  output logic                     HALT,
  output logic                     BUS_OE,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  output logic [15:0]              DATA_OUT,
  output logic                     RAM_RW,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  load_state_e state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] len_q;
  logic [ADDRESS_WIDTH-1:0] count_q;
  logic [ADDRESS_WIDTH-1:0] count_inc;
  logic [SETTLE_W-1:0]      settle_q;
  logic                     accept;

  logic cpu_rst_nxt, halt_nxt, bus_oe_nxt, ram_rw_nxt, busy_nxt, done_nxt;

  assign IN_READY  = (state == ST_FETCH);
  assign accept    = IN_VALID & IN_READY;
  assign count_inc = count_q + ADDRESS_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (LOAD_START) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_q == SETTLE_LAST)
                    state_nxt = (len_q == '0) ? ST_RELEASE : ST_FETCH;
      ST_FETCH:   if (accept) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = ST_HOLD;
      ST_HOLD:    state_nxt = (count_inc == len_q) ? ST_RELEASE : ST_FETCH;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the state being entered.
  always_comb begin
    cpu_rst_nxt = (state_nxt != ST_IDLE);
    busy_nxt    = (state_nxt != ST_IDLE);
    halt_nxt    = (state_nxt == ST_SETTLE) || (state_nxt == ST_FETCH) ||
                  (state_nxt == ST_WRITE)  || (state_nxt == ST_HOLD);
    bus_oe_nxt  = (state_nxt == ST_WRITE) || (state_nxt == ST_HOLD);
    ram_rw_nxt  = (state_nxt == ST_WRITE) ? RAM_RW_WRITE : RAM_RW_READ;
    done_nxt    = (state_nxt == ST_RELEASE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      count_q  <= '0;
      settle_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (LOAD_START) begin
          len_q    <= LOAD_LEN;
          count_q  <= '0;
          settle_q <= '0;
        end
        ST_SETTLE: settle_q <= settle_q + SETTLE_W'(1);
        ST_HOLD:   count_q  <= count_inc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CPU_RST  <= 1'b1;
      HALT     <= 1'b0;
      BUS_OE   <= 1'b0;
      RAM_RW   <= RAM_RW_READ;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ADDRESS  <= START_ADDR;
      DATA_OUT <= '0;
    end else begin
      CPU_RST <= cpu_rst_nxt;
      HALT    <= halt_nxt;
      BUS_OE  <= bus_oe_nxt;
      RAM_RW  <= ram_rw_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
      // Address and data settle with the handshake and stay put through HOLD.
      if (accept) begin
        DATA_OUT <= IN_DATA;
        ADDRESS  <= START_ADDR + count_q;
      end
    end
  end

endmodule

// File: tb/tb_bat_amateur_loader.sv
// Directed bench for bat_amateur_loader: two instances (start address 0 and
// 0xFFFE) share stimulus; a write scoreboard checks every RAM strobe.
module tb_bat_amateur_loader;
  import bat_amateur_pkg::*;

  localparam logic [15:0] START_B = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [15:0] load_len = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;

  logic        a_in_ready, a_cpu_rst, a_halt, a_bus_oe, a_ram_rw, a_busy, a_done;
  logic [15:0] a_address, a_data_out;
  logic        b_in_ready, b_cpu_rst, b_halt, b_bus_oe, b_ram_rw, b_busy, b_done;
  logic [15:0] b_address, b_data_out;

  bat_amateur_loader #(.ADDRESS_WIDTH(16), .START_ADDR(16'h0000), .SETTLE_CYCLES(2)) dut_a (
    .CLK(clk), .RST(rst), .LOAD_START(load_start), .LOAD_LEN(load_len),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(a_in_ready),
    .CPU_RST(a_cpu_rst), .HALT(a_halt), .BUS_OE(a_bus_oe), .ADDRESS(a_address),
    .DATA_OUT(a_data_out), .RAM_RW(a_ram_rw), .BUSY(a_busy), .DONE(a_done)
  );

  bat_amateur_loader #(.ADDRESS_WIDTH(16), .START_ADDR(START_B), .SETTLE_CYCLES(2)) dut_b (
    .CLK(clk), .RST(rst), .LOAD_START(load_start), .LOAD_LEN(load_len),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(b_in_ready),
    .CPU_RST(b_cpu_rst), .HALT(b_halt), .BUS_OE(b_bus_oe), .ADDRESS(b_address),
    .DATA_OUT(b_data_out), .RAM_RW(b_ram_rw), .BUSY(b_busy), .DONE(b_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_a = 0;
  int wr_b = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [15:0] ram_a[int];
  logic [15:0] ram_b[int];
  logic [15:0] wl[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] vec_a();
    return {a_cpu_rst, a_halt, a_bus_oe, a_ram_rw, a_in_ready, a_busy, a_done};
  endfunction

  always @(negedge clk) begin
    if (a_ram_rw === 1'b1) begin
      wr_a++;
      ram_a[int'(a_address)] = a_data_out;
      if (q_a.size() == 0) chk("wr_a_extra", 32'(q_a.size()), 32'd1);
      else chk("wr_a", {a_address, a_data_out}, q_a.pop_front());
    end
    if (b_ram_rw === 1'b1) begin
      wr_b++;
      ram_b[int'(b_address)] = b_data_out;
      if (q_b.size() == 0) chk("wr_b_extra", 32'(q_b.size()), 32'd1);
      else chk("wr_b", {b_address, b_data_out}, q_b.pop_front());
    end
  end

  task automatic run_load(input string tag, input int n, input bit stall, input bit abort,
                          output int done_cyc, output int rst_cyc);
    int  idx = 0;
    int  cyc = 1;
    int  stall_left = stall ? 5 : 0;
    bit  fin = 1'b0;
    done_cyc = 0;
    rst_cyc = 0;
    wr_a = 0;
    wr_b = 0;
    load_len = 16'(n);
    load_start = 1'b1;
    while (!fin) begin
      if (stall && idx == 2 && stall_left > 0) begin
        in_valid = 1'b0;
        if (a_in_ready) begin
          chk({tag, "_stall"}, 32'({a_in_ready, a_halt, a_cpu_rst}), 32'b111);
          if (stall_left == 5) begin
            load_start = 1'b1;
            load_len = 16'd7;
          end
          stall_left--;
        end
      end else begin
        in_valid = 1'b1;
        in_data = (idx < n) ? wl[idx] : 16'hDEAD;
      end
      if (a_in_ready && in_valid && idx < n) begin
        q_a.push_back({16'(idx), wl[idx]});
        q_b.push_back({START_B + 16'(idx), wl[idx]});
        idx++;
      end
      tick();
      cyc++;
      load_start = 1'b0;
      if (a_cpu_rst) rst_cyc++;
      if (abort && a_ram_rw && a_address == 16'd1) begin
        rst = 1'b1;
        tick();
        fin = 1'b1;
      end else if (a_done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else if (cyc > 200) begin
        chk({tag, "_timeout"}, 32'(a_done), 32'd1);
        fin = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_checks(input string tag, input int done_cyc, input int exp_cyc,
                               input int n);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_cyc));
    chk({tag, "_release_vec"}, 32'(vec_a()), 32'b1000011);
    chk({tag, "_wr_a"}, 32'(wr_a), 32'(n));
    chk({tag, "_wr_b"}, 32'(wr_b), 32'(n));
    chk({tag, "_q_empty"}, 32'(q_a.size() + q_b.size()), 32'd0);
    tick();
    chk({tag, "_idle_vec"}, 32'(vec_a()), 32'b0000000);
    chk({tag, "_b_busy"}, 32'(b_busy), 32'd0);
  endtask

  initial begin
    int dc, rc, dones;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_vec", 32'(vec_a()), 32'b1000000);
    chk("reset_addr_a", 32'(a_address), 32'h0000);
    chk("reset_addr_b", 32'(b_address), 32'hFFFE);
    chk("reset_data", 32'(a_data_out), 32'h0000);
    rst = 1'b0;
    chk("reset_cpu_rst_hold", 32'(a_cpu_rst), 32'd1);
    tick();
    chk("reset_cpu_rst_fall", 32'(vec_a()), 32'b0000000);

    wl[0] = 16'h1111; wl[1] = 16'h2222; wl[2] = 16'h3333; wl[3] = 16'h4444;
    run_load("basic", 4, 1'b0, 1'b0, dc, rc);
    finish_checks("basic", dc, 16, 4);
    chk("basic_ram0", 32'(ram_a[0]), 32'h1111);
    chk("basic_ram3", 32'(ram_a[3]), 32'h4444);

    wl[0] = 16'hA001; wl[1] = 16'hA002; wl[2] = 16'hA003; wl[3] = 16'hA004;
    run_load("stall", 4, 1'b1, 1'b0, dc, rc);
    finish_checks("stall", dc, 21, 4);
    chk("stall_ram2", 32'(ram_a[2]), 32'hA003);

    wl[0] = 16'hB00B; wl[1] = 16'hCAFE; wl[2] = 16'h5A5A;
    run_load("wrap", 3, 1'b0, 1'b0, dc, rc);
    finish_checks("wrap", dc, 13, 3);
    chk("wrap_ramb_ffff", 32'(ram_b[65535]), 32'hCAFE);
    chk("wrap_ramb_0000", 32'(ram_b[0]), 32'h5A5A);

    run_load("zero", 0, 1'b0, 1'b0, dc, rc);
    chk("zero_cpu_rst_cycles", 32'(rc), 32'd3);
    finish_checks("zero", dc, 4, 0);

    wl[0] = 16'hD001; wl[1] = 16'hD002; wl[2] = 16'hD003; wl[3] = 16'hD004;
    run_load("abort", 4, 1'b0, 1'b1, dc, rc);
    chk("abort_vec", 32'(vec_a()), 32'b1000000);
    chk("abort_addr_a", 32'(a_address), 32'h0000);
    chk("abort_addr_b", 32'(b_address), 32'hFFFE);
    chk("abort_data", 32'(a_data_out), 32'h0000);
    chk("abort_wr_a", 32'(wr_a), 32'd2);
    chk("abort_ram0", 32'(ram_a[0]), 32'hD001);
    rst = 1'b0;
    dones = 0;
    repeat (4) begin
      tick();
      if (a_done || b_done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle_vec", 32'(vec_a()), 32'b0000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bat_amateur_loader.md
# bat_amateur_loader

Program loader sitting directly upstream of the bat_amateur core on its shared external RAM bus. On command it holds the core in reset and halted, takes a stream of 16-bit program words over a valid/ready input and writes them to consecutive RAM addresses. When the load is complete it releases the bus and the core, which then boots from the new image. Used in simulation as the stimulus source and on hardware behind a host link.

## Interface
- ADDRESS_WIDTH, 16, width of the RAM address bus
- START_ADDR, 0, first RAM address written
- SETTLE_CYCLES, 2, cycles the core is held halted before the first write (≥1)

- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- LOAD_START  in  1  single-cycle request; sampled only in IDLE
- LOAD_LEN  in  ADDRESS_WIDTH  word count, captured with LOAD_START
- IN_DATA  in  16  program word
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  loader accepts a word this cycle
- CPU_RST  out  1  reset to the core
- HALT  out  1  halts the core and grants the loader the RAM bus (drives the core's HALT and EXT_RAM_EN)
- BUS_OE  out  1  loader drives ADDRESS and DATA_OUT onto the shared bus
- ADDRESS  out  ADDRESS_WIDTH  RAM address
- DATA_OUT  out  16  RAM write data
- RAM_RW  out  1  1 = write strobe, 0 = read/idle
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when a load completes

## Operation
- States: IDLE, SETTLE, FETCH, WRITE, HOLD, RELEASE.
- IDLE: CPU_RST=0, HALT=0, BUS_OE=0, IN_READY=0. LOAD_START=1 captures LOAD_LEN, clears the word count and the settle counter, and moves to SETTLE.
- SETTLE: CPU_RST=1, HALT=1, BUS_OE=0. Lasts SETTLE_CYCLES cycles, then goes to FETCH, or to RELEASE if the captured length is 0.
- FETCH: IN_READY=1. When IN_VALID and IN_READY are both high, latch IN_DATA into DATA_OUT and move to WRITE.
- WRITE: BUS_OE=1, RAM_RW=1, ADDRESS = START_ADDR + count. Lasts exactly 1 cycle, then HOLD.
- HOLD: BUS_OE=1, RAM_RW=0, address and data held (hold time for RAM).
  - Increment count.
  - If the new count equals LEN, go to RELEASE; otherwise go to FETCH.
- RELEASE: HALT=0, BUS_OE=0, CPU_RST=1, DONE=1 for this single cycle, then IDLE. The core therefore leaves reset one cycle after the bus is handed back.
- Address arithmetic is modulo 2^ADDRESS_WIDTH. START_ADDR + count wraps to 0 and is not flagged.
- LOAD_LEN=0 is interpreted as 0 words, not 2^ADDRESS_WIDTH. The core is still reset.
- LOAD_START while BUSY is ignored. LOAD_LEN is not re-sampled mid-load.
- IN_VALID outside FETCH is ignored. No data is consumed because IN_READY=0.
- An input stall in FETCH is unbounded. HALT and CPU_RST stay asserted throughout.

## Timing
- All outputs are registered, except IN_READY, which is decoded from the state register.
- Reset values (RST high at an edge):
  - state=IDLE
  - CPU_RST=1 for the reset cycle and the first cycle after it, then 0 from IDLE decoding
  - HALT=0, BUS_OE=0, RAM_RW=0, IN_READY=0, BUSY=0, DONE=0
  - ADDRESS=START_ADDR, DATA_OUT=0
- RST mid-load aborts immediately to the reset values. A partial image remains in RAM. No DONE pulse is produced.
- Per-word cost: 3 cycles minimum (FETCH, WRITE, HOLD).
- Total load with IN_VALID held high: 1 + SETTLE_CYCLES + 3·N + 1 cycles from the LOAD_START edge to the DONE cycle inclusive.

## Structure
- Shared package bat_amateur_pkg holds:
  - loader state enum
  - RAM_RW_WRITE/RAM_RW_READ constants
  - default ADDRESS_WIDTH
- Single module: one FSM, one count register and one settle counter. No sub-module is needed.
- Bus tri-stating stays at the top level and is controlled by BUS_OE.

## Test plan
- **Reset:** hold RST 3 cycles -> all outputs at reset values. CPU_RST falls one cycle after RST falls.
- **Basic load:** LOAD_LEN=4, words 0x1111, 0x2222, 0x3333, 0x4444, IN_VALID always high, START_ADDR=0 -> RAM[0..3] = those words, RAM_RW pulses exactly 4 times, DONE at cycle 16 with SETTLE_CYCLES=2.
- **Stalled input:** drop IN_VALID for 5 cycles between words 2 and 3 -> IN_READY stays high, HALT and CPU_RST stay asserted, no extra writes, final RAM contents correct.
- **Wrap:** START_ADDR=0xFFFE, LOAD_LEN=3 -> writes land at 0xFFFE, 0xFFFF, 0x0000.
- **Zero length:** LOAD_LEN=0 -> no RAM_RW pulse. CPU_RST high for SETTLE_CYCLES+1 cycles, then DONE.
- **Abuse:** LOAD_START during FETCH is ignored. RST asserted during WRITE of word 2 -> immediate IDLE values, no DONE, RAM[0] written and RAM[1] possibly written.
